// File: rtl/display_ctrl_if.sv
// Pixel bus between the timing generator (master) and the display controller (slave).
// The master presents a pixel request plus the three candidate layer colours; the slave returns the arbitrated colour.
interface display_ctrl_if;
  logic       req;
  logic [9:0] col;
  logic [9:0] row;
  logic [7:0] bg_color;
  logic [7:0] snow_color;
  logic       snow_valid;
  logic [7:0] glyph_color;
  logic       glyph_valid;
  logic [7:0] color;

  modport master (
    output req, col, row, bg_color, snow_color, snow_valid, glyph_color, glyph_valid,
    input  color
  );

  modport slave (
    input  req, col, row, bg_color, snow_color, snow_valid, glyph_color, glyph_valid,
    output color
  );
endinterface

// File: rtl/display_ctrl.sv
// Display controller: debounced snow toggle, per-frame latching of the layer configuration,
// and a 1-cycle glyph > snow > background pixel arbiter.
module display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         snowButton,
  input  logic [7:0]   switches,
  display_ctrl_if.slave pix,
  output logic         frame_start,
  output logic         snow_en,
  output logic         glyph_en,
  output logic [3:0]   bg_sel,
  output logic [7:0]   frame_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, HELD, RELEASE} db_state_t;

  db_state_t     state;
  logic [CW-1:0] db_cnt;
  logic          sync_q1, sync_q2;
  logic          toggle_pending;
  logic          fs_hit;

  assign fs_hit = pix.req && (pix.row == 10'd0) && (pix.col == 10'd0);

  // db_cnt holds the number of consecutive samples already seen at the current level,
  // so a transition fires on the DEBOUNCE_CYCLES-th stable sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1        <= 1'b0;
      sync_q2        <= 1'b0;
      state          <= IDLE;
      db_cnt         <= '0;
      toggle_pending <= 1'b0;
    end else begin
      sync_q1 <= snowButton;
      sync_q2 <= sync_q1;
      if (fs_hit)
        toggle_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q2) begin
            state  <= ARM;
            db_cnt <= CW'(1);
          end
        end
        ARM: begin
          if (!sync_q2) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == LAST) begin
            state          <= HELD;
            db_cnt         <= '0;
            // Overrides the frame-boundary clear so a press landing on frame_start is kept.
            toggle_pending <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!sync_q2) begin
            state  <= RELEASE;
            db_cnt <= CW'(1);
          end
        end
        RELEASE: begin
          if (sync_q2) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Arbitration reads the enable registers before this edge's update, so pixel (0,0)
  // still sees the previous frame's configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix.color   <= 8'h00;
      frame_start <= 1'b0;
      snow_en     <= 1'b0;
      glyph_en    <= 1'b0;
      bg_sel      <= 4'h0;
      frame_cnt   <= 8'h00;
    end else begin
      frame_start <= fs_hit;
      if (!pix.req)
        pix.color <= 8'h00;
      else if (glyph_en && pix.glyph_valid)
        pix.color <= pix.glyph_color;
      else if (snow_en && pix.snow_valid)
        pix.color <= pix.snow_color;
      else
        pix.color <= pix.bg_color;
      if (fs_hit) begin
        bg_sel    <= switches[3:0];
        glyph_en  <= switches[4];
        snow_en   <= snow_en ^ toggle_pending;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
// Bench for display_ctrl: directed sequences, an arbitration vector table, and randomized
// traffic compared every cycle against a run-length based reference model.
module tb_display_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       snowButton;
  logic [7:0] switches;
  logic       frame_start, snow_en, glyph_en;
  logic [3:0] bg_sel;
  logic [7:0] frame_cnt;

  display_ctrl_if pix();

  display_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .snowButton(snowButton), .switches(switches), .pix(pix),
    .frame_start(frame_start), .snow_en(snow_en), .glyph_en(glyph_en),
    .bg_sel(bg_sel), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Reference model: a press is the D-th consecutive high synchronized sample while not
  // already held; the hold ends after D consecutive lows.
  logic [1:0] m_sync;
  int         hi_run, lo_run;
  bit         held, pend, m_snow, m_glyph, m_fs;
  logic [3:0] m_bg;
  logic [7:0] m_cnt, m_color;

  always @(posedge clk or posedge rst) begin : model
    bit s, conf, hit;
    int hr, lr;
    if (rst) begin
      m_sync <= 2'b00; hi_run <= 0; lo_run <= 0; held <= 0; pend <= 0;
      m_snow <= 0; m_glyph <= 0; m_fs <= 0; m_bg <= 0; m_cnt <= 0; m_color <= 0;
    end else begin
      s    = m_sync[1];
      hr   = s ? hi_run + 1 : 0;
      lr   = s ? 0 : lo_run + 1;
      conf = s && !held && (hr == D);
      hit  = pix.req && pix.row == 0 && pix.col == 0;
      m_sync <= {m_sync[0], snowButton};
      hi_run <= hr;
      lo_run <= lr;
      if (conf) held <= 1;
      else if (!s && lr == D) held <= 0;
      pend <= (pend && !hit) || conf;
      m_fs <= hit;
      if (!pix.req) m_color <= 8'h00;
      else if (m_glyph && pix.glyph_valid) m_color <= pix.glyph_color;
      else if (m_snow && pix.snow_valid) m_color <= pix.snow_color;
      else m_color <= pix.bg_color;
      if (hit) begin
        m_bg <= switches[3:0];
        m_glyph <= switches[4];
        if (pend) m_snow <= !m_snow;
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  typedef struct {
    bit         req, gv, sv;
    logic [7:0] gc, sc, bc, exp;
  } arb_vec_t;
  arb_vec_t tbl[6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] sw);
    switches = sw;
    pix.req = 1'b1; pix.row = 10'd0; pix.col = 10'd0;
    tick();
    pix.req = 1'b0; pix.row = 10'd1; pix.col = 10'd1;
  endtask

  task automatic press(input int n);
    snowButton = 1'b1;
    repeat (n) tick();
    snowButton = 1'b0;
    repeat (10) tick();
  endtask

  task automatic chk_model();
    chk("rnd_color", pix.color, m_color);
    chk("rnd_frame_start", frame_start, m_fs);
    chk("rnd_snow_en", snow_en, m_snow);
    chk("rnd_glyph_en", glyph_en, m_glyph);
    chk("rnd_bg_sel", bg_sel, m_bg);
    chk("rnd_frame_cnt", frame_cnt, m_cnt);
  endtask

  initial begin
    int hold;
    tbl[0] = '{1, 1, 1, 8'hE0, 8'h1C, 8'h03, 8'hE0};
    tbl[1] = '{1, 0, 1, 8'hE0, 8'h1C, 8'h03, 8'h1C};
    tbl[2] = '{1, 0, 0, 8'hE0, 8'h1C, 8'h03, 8'h03};
    tbl[3] = '{0, 1, 1, 8'hE0, 8'h1C, 8'h03, 8'h00};
    tbl[4] = '{1, 1, 0, 8'h5A, 8'h1C, 8'h03, 8'h5A};
    tbl[5] = '{1, 0, 1, 8'hE0, 8'h77, 8'h03, 8'h77};

    rst = 1'b1; snowButton = 1'b0; switches = 8'h00;
    pix.req = 1'b0; pix.row = 10'd1; pix.col = 10'd1;
    pix.bg_color = 8'h00; pix.snow_color = 8'h00; pix.glyph_color = 8'h00;
    pix.snow_valid = 1'b0; pix.glyph_valid = 1'b0;
    repeat (2) tick();
    chk("rst_color", pix.color, 8'h00);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_enables", {snow_en, glyph_en}, 2'b00);
    chk("rst_bg_sel", bg_sel, 4'h0);
    chk("rst_frame_cnt", frame_cnt, 8'h00);
    rst = 1'b0;
    tick();

    // First frame latches switches
    frame(8'h1A);
    chk("f1_frame_start", frame_start, 1'b1);
    chk("f1_bg_sel", bg_sel, 4'hA);
    chk("f1_glyph_en", glyph_en, 1'b1);
    chk("f1_snow_en", snow_en, 1'b0);
    chk("f1_frame_cnt", frame_cnt, 8'd1);
    switches = 8'h05;
    tick();
    chk("f1_pulse_width", frame_start, 1'b0);
    repeat (5) tick();
    chk("midframe_bg_sel_stable", bg_sel, 4'hA);
    chk("midframe_glyph_stable", glyph_en, 1'b1);

    // Short press rejected, long press applies only at the next frame
    press(3);
    frame(8'h1A);
    chk("short_press_snow", snow_en, 1'b0);
    press(6);
    chk("long_press_before_frame", snow_en, 1'b0);
    frame(8'h1A);
    chk("long_press_at_frame", snow_en, 1'b1);
    chk("f3_frame_cnt", frame_cnt, 8'd3);

    // Arbitration vectors with both layers enabled
    pix.row = 10'd10; pix.col = 10'd10;
    for (int i = 0; i < 6; i++) begin
      pix.req = tbl[i].req; pix.glyph_valid = tbl[i].gv; pix.snow_valid = tbl[i].sv;
      pix.glyph_color = tbl[i].gc; pix.snow_color = tbl[i].sc; pix.bg_color = tbl[i].bc;
      tick();
      chk($sformatf("arb_vec%0d", i), pix.color, tbl[i].exp);
    end
    pix.req = 1'b0;
    tick();

    // Two presses in one frame toggle once
    press(6);
    press(6);
    frame(8'h1A);
    chk("double_press_toggle", snow_en, 1'b0);
    repeat (3) tick();
    frame(8'h1A);
    chk("double_press_no_second", snow_en, 1'b0);

    // Press confirmed on the frame_start edge is deferred one frame
    snowButton = 1'b1;
    repeat (5) tick();
    frame(8'h1A);
    chk("edge_press_frame_start", frame_start, 1'b1);
    chk("edge_press_not_yet", snow_en, 1'b0);
    snowButton = 1'b0;
    repeat (10) tick();
    pix.glyph_valid = 1'b0; pix.snow_valid = 1'b1;
    pix.snow_color = 8'h1C; pix.bg_color = 8'h03;
    frame(8'h1A);
    chk("edge_press_applied", snow_en, 1'b1);
    chk("pixel00_pre_update", pix.color, 8'h03);
    chk("f7_frame_cnt", frame_cnt, 8'd7);
    pix.req = 1'b1; pix.row = 10'd1; pix.col = 10'd2;
    tick();
    chk("pixel_post_update", pix.color, 8'h1C);
    pix.req = 1'b0;

    // frame_cnt wraps after 256 frames from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 1; i <= 256; i++) begin
      frame(8'h00);
      if (i == 255) chk("cnt_255", frame_cnt, 8'd255);
    end
    chk("cnt_wrap", frame_cnt, 8'd0);

    // Asynchronous reset mid-frame and mid-press
    frame(8'hFF);
    snowButton = 1'b1;
    pix.req = 1'b1; pix.row = 10'd5; pix.col = 10'd5;
    pix.glyph_valid = 1'b1; pix.glyph_color = 8'hE0;
    repeat (4) tick();
    chk("pre_rst_color", pix.color, 8'hE0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_color", pix.color, 8'h00);
    chk("async_rst_enables", {frame_start, snow_en, glyph_en}, 3'b000);
    chk("async_rst_bg_sel", bg_sel, 4'h0);
    chk("async_rst_frame_cnt", frame_cnt, 8'h00);
    tick();
    snowButton = 1'b0; pix.req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    frame(8'h13);
    chk("post_rst_bg_sel", bg_sel, 4'h3);
    chk("post_rst_glyph_en", glyph_en, 1'b1);
    chk("post_rst_snow_discarded", snow_en, 1'b0);
    chk("post_rst_frame_cnt", frame_cnt, 8'd1);

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      chk_model();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if (hold == 0) begin
        snowButton = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      switches = 8'($urandom);
      pix.req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        pix.row = 10'd0; pix.col = 10'd0;
      end else begin
        pix.row = 10'($urandom_range(0, 479));
        pix.col = 10'($urandom_range(0, 639));
      end
      pix.bg_color = 8'($urandom); pix.snow_color = 8'($urandom); pix.glyph_color = 8'($urandom);
      pix.snow_valid = 1'($urandom_range(0, 1)); pix.glyph_valid = 1'($urandom_range(0, 1));
      tick();
    end
    chk_model();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
